// File: rtl/lcd_feeder_pkg.sv
// rtl/lcd_feeder_pkg.sv - shared types and constants for the LCD text feeder
package lcd_feeder_pkg;

  // Packer / issue sequencing
  typedef enum logic [1:0] {
    ST_COLLECT    = 2'd0,
    ST_WAIT_AVAIL = 2'd1,
    ST_ISSUE      = 2'd2,
    ST_WAIT_ACK   = 2'd3
  } feeder_state_e;

  // Driver selectCD encoding
  localparam logic SEL_DATA = 1'b1;
  localparam logic SEL_CMD  = 1'b0;

  // ASCII space, used to pad a flushed partial word
  localparam logic [7:0] DEFAULT_PAD_CHAR = 8'h20;

endpackage

// File: rtl/lcd_char_fifo.sv
// rtl/lcd_char_fifo.sv - 8-bit synchronous first-word-fall-through character FIFO
module lcd_char_fifo #(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       rd_en,
  output logic [7:0] rd_data,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);

  // One extra pointer bit tells full (wrapped) apart from empty (same lap)
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [7:0]  mem_q [DEPTH];
  logic        do_wr;
  logic        do_rd;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  // Head entry is always presented, so a pop consumes what is already visible
  assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

  // Advance pointers on accepted writes and reads
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
    if (do_rd) rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
  end

  // Pointer registers; reset empties the FIFO
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/lcd_text_feeder.sv
// rtl/lcd_text_feeder.sv - packs ASCII characters four per word and issues them to the LCD driver
module lcd_text_feeder
  import lcd_feeder_pkg::*;
#(
  parameter int         FIFO_DEPTH  = 16,
  parameter logic [7:0] PAD_CHAR    = DEFAULT_PAD_CHAR,
  parameter int         ACK_TIMEOUT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  char_in,
  input  logic        char_valid,
  output logic        char_ready,
  input  logic [7:0]  cmd_in,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        flush,
  output logic [31:0] lcd_data,
  output logic        lcd_select_cd,
  output logic        lcd_enable_writing,
  input  logic        lcd_available,
  output logic        busy
);

  // Timer counts WAIT_ACK cycles; leaving on TIMER_LAST lands in COLLECT
  // exactly ACK_TIMEOUT cycles after the ISSUE cycle (needs ACK_TIMEOUT >= 2)
  localparam int            TW         = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(ACK_TIMEOUT - 2);

  feeder_state_e state_q, state_d;
  logic [31:0]   word_q, word_d;
  logic [2:0]    count_q, count_d;
  logic          flush_pend_q, flush_pend_d;
  logic [31:0]   lcd_data_q, lcd_data_d;
  logic          sel_q, sel_d;
  logic [TW-1:0] timer_q, timer_d;

  logic          fifo_full;
  logic          fifo_empty;
  logic [7:0]    fifo_rd_data;
  logic          fifo_pop;
  logic          fifo_push;
  logic          cmd_accept;
  logic          flush_clr;

  assign char_ready = !fifo_full && !rst;
  assign fifo_push  = char_valid && char_ready;

  // A command may only start between words, never while characters wait
  assign cmd_ready  = (state_q == ST_COLLECT) && (count_q == 3'd0) &&
                      fifo_empty && !flush_pend_q && !rst;
  assign cmd_accept = cmd_valid && cmd_ready;

  lcd_char_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (fifo_push),
    .wr_data (char_in),
    .rd_en   (fifo_pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Packing, padding, command capture and the issue handshake
  always_comb begin
    state_d    = state_q;
    word_d     = word_q;
    count_d    = count_q;
    lcd_data_d = lcd_data_q;
    sel_d      = sel_q;
    timer_d    = timer_q;
    fifo_pop   = 1'b0;
    flush_clr  = 1'b0;

    case (state_q)
      ST_COLLECT: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          word_d   = {word_q[23:0], fifo_rd_data};
          count_d  = count_q + 3'd1;
        end else if (flush_pend_q && (count_q != 3'd0)) begin
          word_d  = {word_q[23:0], PAD_CHAR};
          count_d = count_q + 3'd1;
        end else if (flush_pend_q) begin
          flush_clr = 1'b1;
        end else if (cmd_accept) begin
          lcd_data_d = {24'h0, cmd_in};
          sel_d      = SEL_CMD;
          state_d    = ST_WAIT_AVAIL;
        end
        // The byte that completes a word is loaded in the same cycle
        if (count_d == 3'd4) begin
          lcd_data_d = word_d;
          sel_d      = SEL_DATA;
          state_d    = ST_WAIT_AVAIL;
        end
      end
      ST_WAIT_AVAIL: begin
        if (lcd_available) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        timer_d = '0;
        state_d = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        timer_d = timer_q + {{(TW-1){1'b0}}, 1'b1};
        if (!lcd_available || (timer_q == TIMER_LAST)) begin
          state_d = ST_COLLECT;
          count_d = 3'd0;
        end
      end
      default: begin
        state_d = ST_COLLECT;
      end
    endcase
  end

  // A new flush request wins over the clear of an older one
  always_comb begin
    flush_pend_d = flush || (flush_pend_q && !flush_clr);
  end

  // State registers; reset discards any pending word and request
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_COLLECT;
      word_q       <= '0;
      count_q      <= 3'd0;
      flush_pend_q <= 1'b0;
      lcd_data_q   <= '0;
      sel_q        <= SEL_DATA;
      timer_q      <= '0;
    end else begin
      state_q      <= state_d;
      word_q       <= word_d;
      count_q      <= count_d;
      flush_pend_q <= flush_pend_d;
      lcd_data_q   <= lcd_data_d;
      sel_q        <= sel_d;
      timer_q      <= timer_d;
    end
  end

  assign lcd_data           = lcd_data_q;
  assign lcd_select_cd      = sel_q;
  assign lcd_enable_writing = (state_q == ST_ISSUE) && !rst;
  assign busy               = (state_q != ST_COLLECT) || (count_q != 3'd0) ||
                              !fifo_empty || flush_pend_q;

endmodule
